// File: rtl/countdown_drain.sv
// rtl/countdown_drain.sv - token drain counter: loads a clipped count and drains it one token per handshake
//
// Purpose:
//    Reader side of the selector-gated accumulator. A load captures
//    min(load_val, LIMIT) into sn. Each accepted token (tok_valid && tok_ready)
//    decrements sn and increments i. The block finishes in DONE when sn
//    reaches zero.
//
// Optional build macro: DRAIN_ABORT_EN
//    Adds the input abort, which leaves DRAIN for IDLE with sn and i held.
//
// Ports:
//    clk        in   system clock, rising edge
//    rst        in   asynchronous active-low reset
//    load       in   load request, sampled in IDLE/DONE only
//    load_val   in   count to drain (WIDTH)
//    selector   in   drain enable, gates tok_valid
//    tok_ready  in   downstream accepts a token
//    abort      in   (DRAIN_ABORT_EN only) abandon the drain, return to IDLE
//    tok_valid  out  token offered this cycle (combinational)
//    sn         out  remaining count (WIDTH, registered)
//    i          out  tokens transferred since last load (WIDTH, registered)
//    busy       out  high in DRAIN (registered)
//    done       out  high in DONE (registered)

module countdown_drain #(
   parameter int WIDTH = 8,
   parameter int LIMIT = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             selector,
   input  logic             tok_ready,
`ifdef DRAIN_ABORT_EN
   input  logic             abort,
`endif
   output logic             tok_valid,
   output logic [WIDTH-1:0] sn,
   output logic [WIDTH-1:0] i,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

   state_t           r_state;
   logic [WIDTH-1:0] r_sn;
   logic [WIDTH-1:0] r_i;
   logic             r_busy;
   logic             r_done;

   logic             w_abort;
   logic             w_xfer;
   logic [WIDTH-1:0] w_clip;

`ifdef DRAIN_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_clip    = (load_val > LIMIT_W) ? LIMIT_W : load_val;
   // abort masks the offer, so no token can slip through on the abort edge
   assign tok_valid = (r_state == S_DRAIN) && selector && !w_abort;
   assign w_xfer    = tok_valid && tok_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_sn    <= '0;
         r_i     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (load) begin
                  r_sn <= w_clip;
                  r_i  <= '0;
                  // a zero load has nothing to drain and goes straight to DONE
                  if (w_clip != '0) begin
                     r_state <= S_DRAIN;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b0;
                  end else begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (w_abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end else if (w_xfer) begin
                  r_sn <= r_sn - WIDTH'(1);
                  r_i  <= r_i + WIDTH'(1);
                  if (r_sn == WIDTH'(1)) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign sn   = r_sn;
   assign i    = r_i;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_countdown_drain.sv
// tb/tb_countdown_drain.sv - directed self-checking bench for countdown_drain

module tb_countdown_drain;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic             selector = 1'b0;
   logic             tok_ready = 1'b0;
   logic             abort = 1'b0;
   logic             tok_valid;
   logic [WIDTH-1:0] sn;
   logic [WIDTH-1:0] i;
   logic             busy;
   logic             done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   countdown_drain #(.WIDTH(WIDTH), .LIMIT(200)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_val  (load_val),
      .selector  (selector),
      .tok_ready (tok_ready),
`ifdef DRAIN_ABORT_EN
      .abort     (abort),
`endif
      .tok_valid (tok_valid),
      .sn        (sn),
      .i         (i),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sn"}, 32'(sn), 0);
      check({tag, "_i"}, 32'(i), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_tv"}, 32'(tok_valid), 0);
   endtask

   // stimulus for the stalled drain of 4: selector, tok_ready, load pulse,
   // and the sn expected at the start of each cycle
   logic       t5_sel [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
   logic       t5_rdy [10] = '{1, 0, 1, 1, 0, 1, 0, 1, 0, 1};
   logic       t5_ld  [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
   int         t5_sn  [10] = '{4, 3, 3, 2, 2, 2, 2, 2, 1, 1};

   int cnt;

   initial begin
      // reset held for two cycles
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_reset_vals("rst_held");
      rst = 1'b1;
      @(negedge clk);
      #1 check_reset_vals("rst_rel");
      repeat (3) @(negedge clk);
      #1 check_reset_vals("idle_hold");

      // plain drain of 5
      load = 1'b1; load_val = 8'd5; selector = 1'b1; tok_ready = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("d5_sn", 32'(sn), 32'(5 - k));
         check("d5_i", 32'(i), 32'(k));
         check("d5_busy", 32'(busy), 1);
         check("d5_done", 32'(done), 0);
         check("d5_tv", 32'(tok_valid), 1);
         @(negedge clk);
      end
      #1;
      check("d5_end_done", 32'(done), 1);
      check("d5_end_busy", 32'(busy), 0);
      check("d5_end_sn", 32'(sn), 0);
      check("d5_end_i", 32'(i), 5);
      check("d5_end_tv", 32'(tok_valid), 0);

      // 250 clipped to 200, loaded from DONE
      load = 1'b1; load_val = 8'd250;
      @(negedge clk);
      load = 1'b0;
      #1;
      check("c200_sn0", 32'(sn), 200);
      check("c200_i0", 32'(i), 0);
      cnt = 0;
      while (!done && cnt < 260) begin
         #1;
         check("c200_sum", 32'(sn) + 32'(i), 200);
         @(negedge clk);
         cnt++;
      end
      #1;
      check("c200_done", 32'(done), 1);
      check("c200_cycles", 32'(cnt), 200);
      check("c200_i", 32'(i), 200);
      check("c200_sn", 32'(sn), 0);

      // zero load goes straight to DONE
      load = 1'b1; load_val = 8'd0;
      #1 check("z_tv_load", 32'(tok_valid), 0);
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("z_done", 32'(done), 1);
         check("z_busy", 32'(busy), 0);
         check("z_tv", 32'(tok_valid), 0);
         check("z_i", 32'(i), 0);
         check("z_sn", 32'(sn), 0);
         @(negedge clk);
      end

      // drain of 4 with back-pressure, selector gaps and an ignored load
      load = 1'b1; load_val = 8'd4;
      @(negedge clk);
      load = 1'b0;
      for (int k = 0; k < 10; k++) begin
         selector = t5_sel[k]; tok_ready = t5_rdy[k];
         load = t5_ld[k]; load_val = 8'd9;
         #1;
         check("s4_sn", 32'(sn), 32'(t5_sn[k]));
         check("s4_sum", 32'(sn) + 32'(i), 4);
         check("s4_tv", 32'(tok_valid), 32'(t5_sel[k]));
         check("s4_busy", 32'(busy), 1);
         check("s4_done", 32'(done), 0);
         @(negedge clk);
      end
      load = 1'b0;
      #1;
      check("s4_end_done", 32'(done), 1);
      check("s4_end_sn", 32'(sn), 0);
      check("s4_end_i", 32'(i), 4);

      // reset asserted mid-drain at sn=3
      selector = 1'b1; tok_ready = 1'b1;
      load = 1'b1; load_val = 8'd10;
      @(negedge clk);
      load = 1'b0;
      repeat (7) @(negedge clk);
      #1 check("mr_sn_before", 32'(sn), 3);
      #2 rst = 1'b0;
      #1 check_reset_vals("mr_async");
      @(negedge clk);
      #1 check_reset_vals("mr_held");
      rst = 1'b1;
      @(negedge clk);
      #1 check_reset_vals("mr_rel");

`ifdef DRAIN_ABORT_EN
      // abort at sn=2 returns to IDLE with counts held
      load = 1'b1; load_val = 8'd4;
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);
      #1 check("ab_sn_pre", 32'(sn), 2);
      abort = 1'b1;
      #1 check("ab_tv", 32'(tok_valid), 0);
      @(negedge clk);
      abort = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("ab_sn", 32'(sn), 2);
         check("ab_i", 32'(i), 2);
         check("ab_busy", 32'(busy), 0);
         check("ab_done", 32'(done), 0);
         check("ab_tv_idle", 32'(tok_valid), 0);
         @(negedge clk);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
